mem_ctrl: RTL and testbench

Memory controller. It is the responder side of the MEM-stage load/store handshake (re_req/wr_req, mem_addr, mem_stage, wr_data, answered by re_data/re_done/wr_done) and also serves the instruction-fetch port. It serialises every access onto the byte-wide RAM bus, one byte per cycle, little-endian. Data accesses take priority over fetches.

---
 rtl/mem_ctrl.sv | 165 ++++++++++++++++
 tb/tb_mem_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Memory controller: serialises MEM-stage loads/stores and instruction fetches onto a
// byte-wide RAM bus, one byte per cycle, little-endian; data accesses beat fetches.
module mem_ctrl #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              re_req,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [1:0]        mem_stage,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] re_data,
    output logic              re_done,
    output logic              wr_done,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_data,
    output logic              if_done,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr
);

    typedef enum logic [2:0] {
        StIdle,
        StDrd,
        StDwr,
        StIfr,
        StDone
    } state_t;

    state_t            r_state;
    logic [2:0]        r_idx;
    logic [2:0]        r_n;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_buf;
    logic [DATA_W-1:0] r_re_data;
    logic [DATA_W-1:0] r_if_data;
    logic              r_re_done;
    logic              r_wr_done;
    logic              r_if_done;
    logic [ADDR_W-1:0] r_ram_a;
    logic [7:0]        r_ram_dout;
    logic              r_ram_wr;

    logic [2:0]        w_n;
    logic [2:0]        w_next_idx;
    logic [ADDR_W-1:0] w_addr_next;
    logic [4:0]        w_cap_sh;
    logic [4:0]        w_wr_sh;

    assign w_n         = {1'b0, mem_stage} + 3'd1;
    assign w_next_idx  = r_idx + 3'd1;
    assign w_addr_next = r_addr + ADDR_W'(w_next_idx);
    // Read data lags the address by one cycle, so cycle k captures byte k-1.
    assign w_cap_sh    = {r_idx[1:0] - 2'd1, 3'b000};
    assign w_wr_sh     = {w_next_idx[1:0], 3'b000};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= StIdle;
            r_idx      <= '0;
            r_n        <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_buf      <= '0;
            r_re_data  <= '0;
            r_if_data  <= '0;
            r_re_done  <= 1'b0;
            r_wr_done  <= 1'b0;
            r_if_done  <= 1'b0;
            r_ram_a    <= '0;
            r_ram_dout <= '0;
            r_ram_wr   <= 1'b0;
        end else begin
            r_re_done <= 1'b0;
            r_wr_done <= 1'b0;
            r_if_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    r_idx <= '0;
                    if (wr_req) begin
                        r_state    <= StDwr;
                        r_addr     <= mem_addr;
                        r_n        <= w_n;
                        r_wdata    <= wr_data;
                        r_ram_a    <= mem_addr;
                        r_ram_dout <= wr_data[7:0];
                        r_ram_wr   <= 1'b1;
                    end else if (re_req) begin
                        r_state   <= StDrd;
                        r_addr    <= mem_addr;
                        r_n       <= w_n;
                        r_re_data <= '0;
                        r_ram_a   <= mem_addr;
                    end else if (if_req && !if_flush) begin
                        r_state <= StIfr;
                        r_addr  <= if_addr;
                        r_n     <= 3'd4;
                        r_ram_a <= if_addr;
                    end
                end
                StDrd, StIfr: begin
                    if (r_state == StIfr && if_flush) begin
                        r_state <= StIdle;
                        r_ram_a <= '0;
                    end else begin
                        if (r_idx != 3'd0) begin
                            if (r_state == StDrd) r_re_data[w_cap_sh +: 8] <= ram_din;
                            else                  r_buf[w_cap_sh +: 8]     <= ram_din;
                        end
                        if (r_idx == r_n) begin
                            r_state <= StDone;
                            if (r_state == StDrd) begin
                                r_re_done <= 1'b1;
                            end else begin
                                // Fetch result is published only on completion so a
                                // flushed fetch leaves if_data untouched.
                                r_if_done <= 1'b1;
                                r_if_data <= {ram_din, r_buf[DATA_W-9:0]};
                            end
                        end
                        r_ram_a <= (w_next_idx < r_n) ? w_addr_next : '0;
                        r_idx   <= w_next_idx;
                    end
                end
                StDwr: begin
                    if (w_next_idx < r_n) begin
                        r_ram_a    <= w_addr_next;
                        r_ram_dout <= r_wdata[w_wr_sh +: 8];
                        r_ram_wr   <= 1'b1;
                        r_idx      <= w_next_idx;
                    end else begin
                        r_state    <= StDone;
                        r_wr_done  <= 1'b1;
                        r_ram_a    <= '0;
                        r_ram_dout <= '0;
                        r_ram_wr   <= 1'b0;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign re_data  = r_re_data;
    assign re_done  = r_re_done;
    assign wr_done  = r_wr_done;
    assign if_data  = r_if_data;
    assign if_done  = r_if_done;
    assign ram_a    = r_ram_a;
    assign ram_dout = r_ram_dout;
    assign ram_wr   = r_ram_wr;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM model with 1-cycle read latency, per-cycle bus trace,
// and a reference memory that predicts load/fetch words and write bytes.
module tb_mem_ctrl;
    localparam int MAXC = 16;

    logic        clk;
    logic        rst;
    logic        re_req, wr_req, if_req, if_flush;
    logic [31:0] mem_addr, wr_data, if_addr;
    logic [1:0]  mem_stage;
    logic [31:0] re_data, if_data, ram_a;
    logic        re_done, wr_done, if_done, ram_wr;
    logic [7:0]  ram_din, ram_dout;

    int errors;
    int checks;

    logic [7:0]  mem     [0:4095];
    logic [7:0]  ref_mem [0:4095];
    logic [39:0] wlog [$];

    logic [31:0] tr_a    [1:MAXC];
    logic        tr_wr   [1:MAXC];
    logic [7:0]  tr_dout [1:MAXC];
    logic [2:0]  tr_done [1:MAXC];
    logic [31:0] tr_re   [1:MAXC];
    logic [31:0] tr_if   [1:MAXC];

    logic [31:0] exp_if_data;

    mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .re_req(re_req), .wr_req(wr_req), .mem_addr(mem_addr), .mem_stage(mem_stage),
        .wr_data(wr_data), .re_data(re_data), .re_done(re_done), .wr_done(wr_done),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_data(if_data),
        .if_done(if_done), .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a),
        .ram_wr(ram_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        ram_din <= mem[ram_a[11:0]];
        if (ram_wr) begin
            mem[ram_a[11:0]] <= ram_dout;
            wlog.push_back({ram_a, ram_dout});
        end
    end

    function automatic logic [7:0] fill(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h3C;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
        logic [31:0] w = '0;
        logic [31:0] ai;
        for (int i = 0; i < n; i++) begin
            ai = a + 32'(i);
            w[8*i +: 8] = ref_mem[ai[11:0]];
        end
        return w;
    endfunction

    task automatic ref_store(input logic [31:0] a, input int n, input logic [31:0] wd);
        logic [31:0] ai;
        for (int i = 0; i < n; i++) begin
            ai = a + 32'(i);
            ref_mem[ai[11:0]] = wd[8*i +: 8];
        end
    endtask

    task automatic pre(input logic [31:0] a, input logic [7:0] d);
        mem[a[11:0]]     = d;
        ref_mem[a[11:0]] = d;
    endtask

    // Expected {ram_a, ram_wr, ram_dout} for address cycle j (1-based) of an n-byte access.
    function automatic logic [40:0] exp_bus(input bit wr, input logic [31:0] a, input int n,
                                            input logic [31:0] wd, input int j);
        if (j < 1 || j > n) return '0;
        return {a + 32'(j - 1), wr, wr ? wd[8*(j-1) +: 8] : 8'h00};
    endfunction

    task automatic launch(input int kind, input logic [31:0] a, input logic [1:0] stage,
                          input logic [31:0] wd);
        @(negedge clk);
        wlog.delete();
        case (kind)
            0: begin re_req = 1'b1; mem_addr = a; mem_stage = stage; end
            1: begin wr_req = 1'b1; mem_addr = a; mem_stage = stage; wr_data = wd; end
            default: begin if_req = 1'b1; if_addr = a; end
        endcase
    endtask

    // Records ncyc cycles; drops each request when its done is seen, as the pipeline would.
    task automatic record(input int ncyc, input int flush_cyc, input logic [31:0] new_if);
        for (int j = 1; j <= ncyc; j++) begin
            @(negedge clk);
            tr_a[j]    = ram_a;
            tr_wr[j]   = ram_wr;
            tr_dout[j] = ram_dout;
            tr_done[j] = {re_done, wr_done, if_done};
            tr_re[j]   = re_data;
            tr_if[j]   = if_data;
            if (re_done) re_req = 1'b0;
            if (wr_done) wr_req = 1'b0;
            if (if_done) if_req = 1'b0;
            if (j == flush_cyc) begin
                if_flush = 1'b1;
                if_addr  = new_if;
            end else begin
                if_flush = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({re_data, if_data} !== 64'h0) begin
            errors++; $display("FAIL reset_data: got re=%h if=%h, want 0", re_data, if_data);
        end
        checks++;
        if ({re_done, wr_done, if_done} !== 3'b000) begin
            errors++; $display("FAIL reset_done: got %b, want 000", {re_done, wr_done, if_done});
        end
        checks++;
        if ({ram_a, ram_dout, ram_wr} !== 41'h0) begin
            errors++; $display("FAIL reset_bus: got a=%h dout=%h wr=%b, want 0", ram_a, ram_dout,
                               ram_wr);
        end
        rst = 1'b1;
        exp_if_data = '0;
    endtask

    task automatic test_lw();
        launch(0, 32'h100, 2'b11, '0);
        record(9, 0, '0);
        for (int j = 1; j <= 9; j++) begin
            checks++;
            if ({tr_a[j], tr_wr[j], tr_dout[j]} !== exp_bus(0, 32'h100, 4, '0, j)) begin
                errors++; $display("FAIL lw_bus c%0d: got a=%h wr=%b dout=%h, want %h", j,
                                   tr_a[j], tr_wr[j], tr_dout[j], exp_bus(0, 32'h100, 4, '0, j));
            end
            checks++;
            if (tr_done[j] !== ((j == 6) ? 3'b100 : 3'b000)) begin
                errors++; $display("FAIL lw_done c%0d: got %b", j, tr_done[j]);
            end
        end
        checks++;
        if (tr_re[6] !== 32'h44332211) begin
            errors++; $display("FAIL lw_data: got %h, want 44332211", tr_re[6]);
        end
    endtask

    task automatic test_sh();
        launch(1, 32'h2FFE, 2'b01, 32'hAABBCCDD);
        record(9, 0, '0);
        ref_store(32'h2FFE, 2, 32'hAABBCCDD);
        for (int j = 1; j <= 9; j++) begin
            checks++;
            if ({tr_a[j], tr_wr[j], tr_dout[j]} !== exp_bus(1, 32'h2FFE, 2, 32'hAABBCCDD, j)) begin
                errors++; $display("FAIL sh_bus c%0d: got a=%h wr=%b dout=%h", j, tr_a[j],
                                   tr_wr[j], tr_dout[j]);
            end
            checks++;
            if (tr_done[j] !== ((j == 3) ? 3'b010 : 3'b000)) begin
                errors++; $display("FAIL sh_done c%0d: got %b", j, tr_done[j]);
            end
        end
        checks++;
        if (wlog.size() != 2) begin
            errors++; $display("FAIL sh_wcount: got %0d writes, want 2", wlog.size());
        end else if (wlog[0] !== {32'h2FFE, 8'hDD} || wlog[1] !== {32'h2FFF, 8'hCC}) begin
            errors++; $display("FAIL sh_wlog: got %h %h", wlog[0], wlog[1]);
        end
    endtask

    task automatic test_lb_after_lw();
        launch(0, 32'h200, 2'b11, '0);
        record(9, 0, '0);
        checks++;
        if (tr_re[6] !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL lb_pre_lw: got %h, want ffffffff", tr_re[6]);
        end
        launch(0, 32'h300, 2'b00, '0);
        record(9, 0, '0);
        checks++;
        if (tr_re[1] !== 32'h0) begin
            errors++; $display("FAIL lb_clear: got %h, want 0", tr_re[1]);
        end
        for (int j = 1; j <= 9; j++) begin
            checks++;
            if ({tr_a[j], tr_wr[j], tr_dout[j]} !== exp_bus(0, 32'h300, 1, '0, j) ||
                tr_done[j] !== ((j == 3) ? 3'b100 : 3'b000)) begin
                errors++; $display("FAIL lb_cycle c%0d: got a=%h wr=%b done=%b", j, tr_a[j],
                                   tr_wr[j], tr_done[j]);
            end
        end
        checks++;
        if (tr_re[3] !== 32'h00000080) begin
            errors++; $display("FAIL lb_data: got %h, want 00000080", tr_re[3]);
        end
    endtask

    task automatic test_arbitration();
        logic [40:0] e;
        @(negedge clk);
        re_req = 1'b1; mem_addr = 32'h100; mem_stage = 2'b11;
        if_req = 1'b1; if_addr = 32'h600;
        record(16, 0, '0);
        for (int j = 1; j <= 16; j++) begin
            e = exp_bus(0, 32'h100, 4, '0, j) | exp_bus(0, 32'h600, 4, '0, j - 7);
            checks++;
            if ({tr_a[j], tr_wr[j], tr_dout[j]} !== e) begin
                errors++; $display("FAIL arb_bus c%0d: got a=%h wr=%b, want %h", j, tr_a[j],
                                   tr_wr[j], e);
            end
            checks++;
            if (tr_done[j] !== ((j == 6) ? 3'b100 : (j == 13) ? 3'b001 : 3'b000)) begin
                errors++; $display("FAIL arb_done c%0d: got %b", j, tr_done[j]);
            end
        end
        checks++;
        if (tr_re[6] !== 32'h44332211 || tr_if[13] !== ref_word(32'h600, 4)) begin
            errors++; $display("FAIL arb_data: got re=%h if=%h, want 44332211 %h", tr_re[6],
                               tr_if[13], ref_word(32'h600, 4));
        end
        exp_if_data = ref_word(32'h600, 4);
    endtask

    task automatic test_flush();
        logic [31:0] prev;
        logic [40:0] e;
        prev = exp_if_data;
        launch(2, 32'h80, 2'b00, '0);
        record(12, 3, 32'h40);
        for (int j = 1; j <= 12; j++) begin
            e = exp_bus(0, 32'h80, 3, '0, j) | exp_bus(0, 32'h40, 4, '0, j - 4);
            checks++;
            if ({tr_a[j], tr_wr[j], tr_dout[j]} !== e) begin
                errors++; $display("FAIL flush_bus c%0d: got a=%h wr=%b, want %h", j, tr_a[j],
                                   tr_wr[j], e);
            end
            checks++;
            if (tr_done[j] !== ((j == 10) ? 3'b001 : 3'b000)) begin
                errors++; $display("FAIL flush_done c%0d: got %b", j, tr_done[j]);
            end
            if (j <= 9) begin
                checks++;
                if (tr_if[j] !== prev) begin
                    errors++; $display("FAIL flush_hold c%0d: got %h, want %h", j, tr_if[j], prev);
                end
            end
        end
        exp_if_data = ref_word(32'h40, 4);
        checks++;
        if (tr_if[10] !== exp_if_data) begin
            errors++; $display("FAIL flush_refetch: got %h, want %h", tr_if[10], exp_if_data);
        end
    endtask

    task automatic test_reset_mid_store();
        logic seen;
        launch(1, 32'h500, 2'b11, 32'hCAFEBABE);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({re_data, if_data, re_done, wr_done, if_done, ram_a, ram_dout, ram_wr} !== '0) begin
            errors++; $display("FAIL rst_mid_outputs: got re=%h if=%h done=%b a=%h dout=%h wr=%b",
                               re_data, if_data, {re_done, wr_done, if_done}, ram_a, ram_dout,
                               ram_wr);
        end
        rst = 1'b1;
        wr_req = 1'b0;
        ref_store(32'h500, 2, 32'hCAFEBABE);
        exp_if_data = '0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | wr_done;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL rst_mid_nodone: got wr_done pulse, want none");
        end
        launch(1, 32'h500, 2'b11, 32'h13579BDF);
        record(9, 0, '0);
        ref_store(32'h500, 4, 32'h13579BDF);
        for (int j = 1; j <= 9; j++) begin
            checks++;
            if ({tr_a[j], tr_wr[j], tr_dout[j]} !== exp_bus(1, 32'h500, 4, 32'h13579BDF, j) ||
                tr_done[j] !== ((j == 5) ? 3'b010 : 3'b000)) begin
                errors++; $display("FAIL rst_reissue c%0d: got a=%h wr=%b dout=%h done=%b", j,
                                   tr_a[j], tr_wr[j], tr_dout[j], tr_done[j]);
            end
        end
    endtask

    task automatic test_random();
        int          kind, n, dc;
        logic [31:0] a, wd, ed;
        logic [1:0]  st;
        logic [2:0]  dv;
        logic [31:0] bases [3];
        bases[0] = 32'h0000_1000;
        bases[1] = 32'hFFFF_FFF8;
        bases[2] = 32'h7FFF_FFFE;
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 2);
            a    = bases[$urandom_range(0, 2)] + 32'($urandom_range(0, 15));
            st   = 2'($urandom_range(0, 3));
            wd   = $urandom;
            n    = (kind == 2) ? 4 : int'(st) + 1;
            dc   = (kind == 1) ? n + 1 : n + 2;
            dv   = (kind == 0) ? 3'b100 : (kind == 1) ? 3'b010 : 3'b001;
            ed   = ref_word(a, n);
            launch(kind, a, st, wd);
            record(9, 0, '0);
            for (int j = 1; j <= 9; j++) begin
                checks++;
                if ({tr_a[j], tr_wr[j], tr_dout[j]} !== exp_bus(kind == 1, a, n, wd, j) ||
                    tr_done[j] !== ((j == dc) ? dv : 3'b000)) begin
                    errors++; $display("FAIL rand%0d_c%0d: kind=%0d a=%h got a=%h wr=%b dout=%h done=%b",
                                       t, j, kind, a, tr_a[j], tr_wr[j], tr_dout[j], tr_done[j]);
                end
            end
            if (kind == 1) begin
                ref_store(a, n, wd);
                checks++;
                if (wlog.size() != n) begin
                    errors++; $display("FAIL rand%0d_wcount: got %0d, want %0d", t, wlog.size(), n);
                end
            end else if (kind == 0) begin
                checks++;
                if (tr_re[dc] !== ed) begin
                    errors++; $display("FAIL rand%0d_load: got %h, want %h", t, tr_re[dc], ed);
                end
            end else begin
                exp_if_data = ed;
                checks++;
                if (tr_if[dc] !== ed) begin
                    errors++; $display("FAIL rand%0d_fetch: got %h, want %h", t, tr_if[dc], ed);
                end
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0;
        re_req = 1'b0; wr_req = 1'b0; if_req = 1'b0; if_flush = 1'b0;
        mem_addr = '0; wr_data = '0; if_addr = '0; mem_stage = '0;
        exp_if_data = '0;
        for (int i = 0; i < 4096; i++) begin
            mem[i]     = fill(32'(i));
            ref_mem[i] = fill(32'(i));
        end
        pre(32'h100, 8'h11); pre(32'h101, 8'h22); pre(32'h102, 8'h33); pre(32'h103, 8'h44);
        pre(32'h200, 8'hFF); pre(32'h201, 8'hFF); pre(32'h202, 8'hFF); pre(32'h203, 8'hFF);
        pre(32'h300, 8'h80);

        test_reset();
        test_lw();
        test_sh();
        test_lb_after_lw();
        test_arbitration();
        test_flush();
        test_reset_mid_store();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
